// File: rtl/div_share_arbiter.sv
// div_share_arbiter
// Shares one iterative 32/16 divider among NREQ requesters. A round-robin
// arbiter picks one pending request, its operands are latched and handed to
// the divider, and the quotient/remainder come back tagged with the requester
// index. A zero divisor is answered directly without starting the divider,
// and a watchdog turns a divider that never signals done into an error
// response.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready is one-hot or 0)
//   req_dividend      packed dividends, slice i = [i*2*WL +: 2*WL]
//   req_divisor       packed divisors,  slice i = [i*WL +: WL]
//   req_unsigned      per-requester mode, 1 = unsigned
//   div_start         one-cycle start pulse to the divider
//   div_dividend/divisor/unsigned  registered operands to the divider
//   div_done/quotient/remainder/overflow  divider result
//   rsp_valid/ready   response handshake
//   rsp_id            index of the requester the response belongs to
//   rsp_quotient/remainder/overflow/err  response payload
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; accept one request
// ISSUE | pulse div_start, clear watchdog
// BUSY  | wait for div_done or watchdog expiry
// RESP  | hold response until rsp_ready
module div_share_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int WL      = 16,
  parameter  int TIMEOUT = 31,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WDW     = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*2*WL-1:0]   req_dividend,
  input  logic [NREQ*WL-1:0]     req_divisor,
  input  logic [NREQ-1:0]        req_unsigned,
  output logic                   div_start,
  output logic [2*WL-1:0]        div_dividend,
  output logic [WL-1:0]          div_divisor,
  output logic                   div_unsigned,
  input  logic                   div_done,
  input  logic [WL-1:0]          div_quotient,
  input  logic [WL-1:0]          div_remainder,
  input  logic                   div_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WL-1:0]          rsp_quotient,
  output logic [WL-1:0]          rsp_remainder,
  output logic                   rsp_overflow,
  output logic                   rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    cand;
  logic              grant_found;
  logic              hs;
  logic [WDW-1:0]    wdog;
  logic              wd_expire;
  logic [2*WL-1:0]   sel_dividend;
  logic [WL-1:0]     sel_divisor;
  logic              sel_unsigned;
  logic              sel_zero;

  // (base + off) mod NREQ, with off < NREQ
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_idx(rr_ptr, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // req_ready only goes to a requester that is already valid, so a grant in
  // IDLE is the handshake itself.
  assign hs           = (state == IDLE) && grant_found;
  assign sel_dividend = req_dividend[int'(grant_idx)*2*WL +: 2*WL];
  assign sel_divisor  = req_divisor[int'(grant_idx)*WL +: WL];
  assign sel_unsigned = req_unsigned[grant_idx];
  assign sel_zero     = (sel_divisor == '0);
  // wdog counts BUSY cycles from 0; expiring at TIMEOUT-1 makes the error
  // response appear TIMEOUT+1 cycles after div_start.
  assign wd_expire    = (wdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (hs) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt = sel_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (div_done || wd_expire) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      wdog          <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_unsigned  <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_overflow  <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            rsp_id       <= grant_idx;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            div_unsigned <= sel_unsigned;
            rr_ptr       <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
            if (sel_zero) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_dividend[WL-1:0];
              rsp_overflow  <= 1'b1;
              rsp_err       <= 1'b0;
            end
          end
        end
        ISSUE: wdog <= '0;
        BUSY: begin
          wdog <= wdog + WDW'(1);
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_overflow  <= div_overflow;
            rsp_err       <= 1'b0;
          end else if (wd_expire) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_overflow  <= 1'b1;
            rsp_err       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Testbench for div_share_arbiter: directed steps with a simple divider model
// that answers k cycles after div_start (k = 0 means never).
module tb_div_share_arbiter;
  localparam int NREQ    = 4;
  localparam int WL      = 16;
  localparam int TIMEOUT = 31;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*2*WL-1:0]  req_dividend;
  logic [NREQ*WL-1:0]    req_divisor;
  logic [NREQ-1:0]       req_unsigned;
  logic                  div_start;
  logic [2*WL-1:0]       div_dividend;
  logic [WL-1:0]         div_divisor;
  logic                  div_unsigned;
  logic                  div_done;
  logic [WL-1:0]         div_quotient;
  logic [WL-1:0]         div_remainder;
  logic                  div_overflow;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WL-1:0]         rsp_quotient;
  logic [WL-1:0]         rsp_remainder;
  logic                  rsp_overflow;
  logic                  rsp_err;

  div_share_arbiter #(.NREQ(NREQ), .WL(WL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_unsigned(req_unsigned),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_unsigned(div_unsigned), .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_overflow(div_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // divider model
  int model_k = 16;
  int pend    = 0;
  logic [31:0] lat_q, lat_r;
  initial begin
    div_done = 1'b0; div_quotient = '0; div_remainder = '0; div_overflow = 1'b0;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          div_done      = 1'b1;
          div_quotient  = lat_q[15:0];
          div_remainder = lat_r[15:0];
          div_overflow  = 1'b0;
        end
      end
      if (div_start) begin
        lat_q = div_dividend / {16'd0, div_divisor};
        lat_r = div_dividend % {16'd0, div_divisor};
        if (model_k > 0) pend = model_k;
      end
    end
  end

  // monitor
  int hs_count = 0, hs_cyc = 0, hs_id = -1;
  int start_count = 0, start_cyc = 0;
  int rise_count = 0, rise_cyc = 0;
  int rsphs_count = 0;
  int onehot_bad = 0, ready_in_resp = 0, unstable = 0;
  int grant_q[$], rspid_q[$], rspq_q[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [1:0] p_id;
  logic [15:0] p_q, p_r;
  logic p_o, p_e;
  always @(negedge clk) begin
    int id;
    if ($countones(req_ready) > 1) onehot_bad++;
    if (rsp_valid && (req_ready != '0)) ready_in_resp++;
    if (|(req_valid & req_ready)) begin
      id = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) id = i;
      hs_count++; hs_cyc = cyc; hs_id = id;
      grant_q.push_back(id);
    end
    if (div_start) begin start_count++; start_cyc = cyc; end
    if (rsp_valid && !prev_v) begin rise_count++; rise_cyc = cyc; end
    if (prev_v && !prev_r) begin
      if (!rsp_valid || rsp_id != p_id || rsp_quotient != p_q || rsp_remainder != p_r ||
          rsp_overflow != p_o || rsp_err != p_e) unstable++;
    end
    if (rsp_valid && rsp_ready) begin
      rsphs_count++;
      rspid_q.push_back(int'(rsp_id));
      rspq_q.push_back(int'(rsp_quotient));
    end
    prev_v = rsp_valid; prev_r = rsp_ready;
    p_id = rsp_id; p_q = rsp_quotient; p_r = rsp_remainder; p_o = rsp_overflow; p_e = rsp_err;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input string tag);
    int b = 0;
    while (hs_count < target && b < 200) begin @(posedge clk); b++; end
    chk({tag, " grant reached"}, int'(hs_count >= target), 1);
  endtask

  task automatic wait_rise(input int target, input string tag);
    int b = 0;
    while (rise_count < target && b < 200) begin @(posedge clk); b++; end
    chk({tag, " rsp_valid reached"}, int'(rise_count >= target), 1);
  endtask

  task automatic wait_rsphs(input int target, input string tag);
    int b = 0;
    while (rsphs_count < target && b < 400) begin @(posedge clk); b++; end
    chk({tag, " rsp handshakes reached"}, int'(rsphs_count >= target), 1);
  endtask

  task automatic set_req(input int i, input logic [31:0] dd, input logic [15:0] dv, input logic u);
    req_dividend[i*32 +: 32] = dd;
    req_divisor[i*16 +: 16]  = dv;
    req_unsigned[i]          = u;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, s0, r0, rdy_cyc;
    int exp_g[5];
    int exp_q[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_q = '{32'h21, 32'h42, 32'h64, 32'h85, 32'h21};

    rst_n = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0;
    req_unsigned = '0; rsp_ready = 1'b0;
    tick(3);
    chk("reset req_ready", int'(req_ready), 0);
    chk("reset div_start", int'(div_start), 0);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset div_dividend", int'(div_dividend), 0);
    chk("reset rsp_payload", int'({rsp_id, rsp_overflow, rsp_err, rsp_quotient}), 0);
    rst_n = 1'b1;
    tick(2);

    // all four requesters continuously valid from reset
    model_k = 3;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'((i + 1) * 100), 16'd3, 1'b1);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    wait_hs(5, "rr");
    #1 req_valid = '0;
    wait_rsphs(5, "rr");
    #1 rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr grant[%0d]", k), (grant_q.size() > k) ? grant_q[k] : -1, exp_g[k]);
      chk($sformatf("rr rsp_id[%0d]", k), (rspid_q.size() > k) ? rspid_q[k] : -1, exp_g[k]);
      chk($sformatf("rr quotient[%0d]", k), (rspq_q.size() > k) ? rspq_q[k] : -1, exp_q[k]);
    end
    chk("rr req_ready one-hot", onehot_bad, 0);
    tick(2);

    // single request from requester 2, k = 16
    model_k = 16;
    set_req(2, 32'h0000_0064, 16'h0007, 1'b1);
    n0 = hs_count; s0 = start_count; r0 = rise_count;
    req_valid = 4'b0100;
    wait_hs(n0 + 1, "single");
    #1 req_valid = '0;
    wait_rise(r0 + 1, "single");
    #1;
    chk("single grant id", hs_id, 2);
    chk("single start latency", start_cyc - hs_cyc, 1);
    chk("single start count", start_count - s0, 1);
    chk("single rsp latency", rise_cyc - hs_cyc, 18);
    chk("single rsp_id", int'(rsp_id), 2);
    chk("single quotient", int'(rsp_quotient), 32'h000E);
    chk("single remainder", int'(rsp_remainder), 32'h0002);
    chk("single overflow", int'(rsp_overflow), 0);
    chk("single err", int'(rsp_err), 0);
    release_rsp();
    chk("single rsp_valid after accept", int'(rsp_valid), 0);

    // divide by zero from requester 1
    set_req(1, 32'h0000_1234, 16'h0000, 1'b1);
    n0 = hs_count; s0 = start_count; r0 = rise_count;
    req_valid = 4'b0010;
    wait_hs(n0 + 1, "dbz");
    #1 req_valid = '0;
    wait_rise(r0 + 1, "dbz");
    #1;
    chk("dbz rsp latency", rise_cyc - hs_cyc, 1);
    chk("dbz rsp_id", int'(rsp_id), 1);
    chk("dbz quotient", int'(rsp_quotient), 32'hFFFF);
    chk("dbz remainder", int'(rsp_remainder), 32'h1234);
    chk("dbz overflow", int'(rsp_overflow), 1);
    chk("dbz err", int'(rsp_err), 0);
    release_rsp();
    tick(2);
    chk("dbz no div_start", start_count - s0, 0);

    // divider never answers: watchdog response
    model_k = 0;
    set_req(3, 32'd500, 16'd5, 1'b1);
    n0 = hs_count; r0 = rise_count;
    req_valid = 4'b1000;
    wait_hs(n0 + 1, "wdog");
    #1 req_valid = '0;
    wait_rise(r0 + 1, "wdog");
    #1;
    chk("wdog rsp latency from start", rise_cyc - start_cyc, TIMEOUT + 1);
    chk("wdog rsp_id", int'(rsp_id), 3);
    chk("wdog err", int'(rsp_err), 1);
    chk("wdog overflow", int'(rsp_overflow), 1);
    chk("wdog quotient", int'(rsp_quotient), 0);
    chk("wdog remainder", int'(rsp_remainder), 0);
    release_rsp();

    // response back-pressure for 10 cycles with another requester waiting
    model_k = 4;
    set_req(0, 32'd1000, 16'd9, 1'b1);
    set_req(1, 32'd50, 16'd5, 1'b1);
    n0 = hs_count; r0 = rise_count;
    req_valid = 4'b0011;
    wait_hs(n0 + 1, "bp");
    #1 req_valid = 4'b0010;
    chk("bp first grant id", hs_id, 0);
    wait_rise(r0 + 1, "bp");
    #1;
    s0 = unstable; n0 = ready_in_resp;
    tick(10);
    chk("bp rsp stable", unstable - s0, 0);
    chk("bp no req_ready in RESP", ready_in_resp - n0, 0);
    chk("bp rsp_valid held", int'(rsp_valid), 1);
    chk("bp rsp_id", int'(rsp_id), 0);
    chk("bp quotient", int'(rsp_quotient), 32'h6F);
    chk("bp remainder", int'(rsp_remainder), 32'h1);
    n0 = hs_count;
    rsp_ready = 1'b1;
    rdy_cyc = cyc;
    tick(1);
    rsp_ready = 1'b0;
    wait_hs(n0 + 1, "bp next");
    #1 req_valid = '0;
    chk("bp next grant cycle", hs_cyc - rdy_cyc, 1);
    chk("bp next grant id", hs_id, 1);
    wait_rise(r0 + 2, "bp next");
    #1;
    chk("bp next rsp_id", int'(rsp_id), 1);
    chk("bp next quotient", int'(rsp_quotient), 32'hA);
    release_rsp();

    // reset while BUSY; the late div_done must be ignored
    model_k = 16;
    set_req(2, 32'h0000_0064, 16'h0007, 1'b1);
    n0 = hs_count;
    req_valid = 4'b0100;
    wait_hs(n0 + 1, "rst");
    #1 req_valid = '0;
    tick(4);
    chk("rst pre div_divisor", int'(div_divisor), 7);
    rst_n = 1'b0;
    #1;
    chk("rst async div_dividend", int'(div_dividend), 0);
    chk("rst async div_divisor", int'(div_divisor), 0);
    chk("rst async div_unsigned", int'(div_unsigned), 0);
    chk("rst async rsp_id", int'(rsp_id), 0);
    s0 = start_count; r0 = rise_count;
    tick(2);
    rst_n = 1'b1;
    tick(25);
    chk("rst late done no rsp", rise_count - r0, 0);
    chk("rst rsp_valid low", int'(rsp_valid), 0);
    chk("rst no new start", start_count - s0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
